// File: rtl/prefetch_pkg.sv
// Shared types and widths for the instruction prefetch path.
package prefetch_pkg;

  localparam int unsigned PHYS_ADDR_W = 20;
  localparam int unsigned WORD_ADDR_W = PHYS_ADDR_W - 1;
  localparam int unsigned DATA_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_LO,
    FETCH_HI,
    PUSH
  } prefetch_state_t;

endpackage

// File: rtl/segment_address.sv
// Real-mode segment:offset to 16-bit word address, wrapping at 1 MiB.
module segment_address
  import prefetch_pkg::*;
(
  input  logic [15:0]            cs,
  input  logic [15:0]            ip,
  output logic [WORD_ADDR_W-1:0] word_addr_c
);

  // Sum is taken at 20 bits so the carry out of bit 19 is dropped.
  always_comb begin
    word_addr_c = WORD_ADDR_W'(({cs, 4'h0} + PHYS_ADDR_W'(ip)) >> 1);
  end

endmodule

// File: rtl/instruction_prefetch.sv
// Fetches 16-bit code words at CS:IP in pairs and pushes them into the decoder FIFO.
module instruction_prefetch
  import prefetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_new_ip,
  input  logic [15:0]            new_cs,
  input  logic [15:0]            new_ip,
  output logic                   fifo_wr_en,
  output logic [31:0]            fifo_wr_data,
  input  logic                   fifo_full,
  output logic                   fifo_reset,
  output logic                   mem_access,
  output logic [WORD_ADDR_W-1:0] mem_address,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_data,
  output logic [15:0]            fetch_ip
);

  prefetch_state_t       state_q, state_d;
  logic                  abort_q, abort_d;
  logic [15:0]           cs_q, cs_d;
  logic [15:0]           ip_q, ip_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic                  mem_access_q, mem_access_d;
  logic [WORD_ADDR_W-1:0] mem_address_q, mem_address_d;
  logic                  fifo_wr_en_q, fifo_wr_en_d;
  logic                  fifo_reset_q, fifo_reset_d;
  logic [WORD_ADDR_W-1:0] seg_addr_c;

  segment_address u_segment_address (
    .cs          (cs_d),
    .ip          (ip_d),
    .word_addr_c (seg_addr_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      abort_q       <= 1'b0;
      cs_q          <= '0;
      ip_q          <= '0;
      lo_q          <= '0;
      hi_q          <= '0;
      mem_access_q  <= 1'b0;
      mem_address_q <= '0;
      fifo_wr_en_q  <= 1'b0;
      fifo_reset_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      abort_q       <= abort_d;
      cs_q          <= cs_d;
      ip_q          <= ip_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      mem_access_q  <= mem_access_d;
      mem_address_q <= mem_address_d;
      fifo_wr_en_q  <= fifo_wr_en_d;
      fifo_reset_q  <= fifo_reset_d;
    end
  end

  // A restart wins over everything; an abort wait only swallows the stale ack.
  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    cs_d    = cs_q;
    ip_d    = ip_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    if (load_new_ip) begin
      state_d = FETCH_LO;
      abort_d = mem_access_q && !mem_ack;
      cs_d    = new_cs;
      ip_d    = new_ip & 16'hFFFE;
    end else if (abort_q) begin
      if (mem_ack) abort_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE:     state_d = IDLE;
        FETCH_LO: if (mem_ack) begin
                    lo_d    = mem_data;
                    ip_d    = ip_q + 16'd2;
                    state_d = FETCH_HI;
                  end
        FETCH_HI: if (mem_ack) begin
                    hi_d    = mem_data;
                    ip_d    = ip_q + 16'd2;
                    state_d = PUSH;
                  end
        PUSH:     if (!fifo_full) state_d = FETCH_LO;
        default:  state_d = IDLE;
      endcase
    end
  end

  // During an abort wait the old request address is held until its ack.
  always_comb begin
    fifo_wr_en_d  = (state_q == PUSH) && !fifo_full && !load_new_ip;
    fifo_reset_d  = load_new_ip;
    mem_access_d  = abort_d || (state_d inside {FETCH_LO, FETCH_HI});
    mem_address_d = abort_d ? mem_address_q : seg_addr_c;
  end

  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = {hi_q, lo_q};
  assign fifo_reset   = fifo_reset_q;
  assign mem_access   = mem_access_q;
  assign mem_address  = mem_address_q;
  assign fetch_ip     = ip_q;

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed scenarios plus randomized traffic checked against a word-queue reference model.
module tb_instruction_prefetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_new_ip = 1'b0;
  logic [15:0] new_cs = '0;
  logic [15:0] new_ip = '0;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_full = 1'b0;
  logic        fifo_reset;
  logic        mem_access;
  logic [18:0] mem_address;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = '0;
  logic [15:0] fetch_ip;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_prefetch dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_new_ip  (load_new_ip),
    .new_cs       (new_cs),
    .new_ip       (new_ip),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .fifo_reset   (fifo_reset),
    .mem_access   (mem_access),
    .mem_address  (mem_address),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .fetch_ip     (fetch_ip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] phys_word(input logic [15:0] cs, input logic [15:0] ip);
    int unsigned p;
    p = (32'(cs) * 32'd16 + 32'(ip)) % 32'h0010_0000;
    return 19'(p / 2);
  endfunction

  // Reference model: target CS:IP, a queue of collected words, and a pending stale ack.
  bit          m_run, m_abort;
  logic [15:0] m_cs, m_ip;
  logic [15:0] m_words[$];
  logic        e_acc = 1'b0, e_wr = 1'b0, e_rst = 1'b0;
  logic [18:0] e_addr = '0;
  logic [31:0] e_data = '0;
  logic [15:0] e_ip = '0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_run = 0; m_abort = 0; m_cs = '0; m_ip = '0; m_words.delete();
        e_acc = 0; e_wr = 0; e_rst = 0; e_addr = '0; e_data = '0; e_ip = '0;
      end else begin
        e_wr  = 1'b0;
        e_rst = load_new_ip;
        if (load_new_ip) begin
          m_abort = e_acc && !mem_ack;
          m_cs = new_cs;
          m_ip = new_ip & 16'hFFFE;
          m_words.delete();
          m_run = 1;
          e_acc = 1'b1;
          if (!m_abort) e_addr = phys_word(m_cs, m_ip);
        end else if (m_abort) begin
          if (mem_ack) begin
            m_abort = 0;
            e_addr = phys_word(m_cs, m_ip);
          end
        end else if (m_run) begin
          if (m_words.size() < 2) begin
            if (mem_ack) begin
              m_words.push_back(mem_data);
              m_ip  = m_ip + 16'd2;
              e_acc = (m_words.size() < 2);
              e_addr = phys_word(m_cs, m_ip);
            end
          end else if (!fifo_full) begin
            e_wr   = 1'b1;
            e_data = {m_words[1], m_words[0]};
            m_words.delete();
            e_acc  = 1'b1;
            e_addr = phys_word(m_cs, m_ip);
          end
        end
        e_ip = m_ip;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("model mem_access", 32'(mem_access), 32'(e_acc));
      chk("model fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
      chk("model fifo_reset", 32'(fifo_reset), 32'(e_rst));
      chk("model fetch_ip", 32'(fetch_ip), 32'(e_ip));
      if (e_acc) chk("model mem_address", 32'(mem_address), 32'(e_addr));
      if (e_wr)  chk("model fifo_wr_data", fifo_wr_data, e_data);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset mem_access", 32'(mem_access), 32'h0);
    chk("reset mem_address", 32'(mem_address), 32'h0);
    chk("reset fifo_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("reset fifo_wr_data", fifo_wr_data, 32'h0);
    chk("reset fifo_reset", 32'(fifo_reset), 32'h0);
    chk("reset fetch_ip", 32'(fetch_ip), 32'h0);
    reset_n = 1'b1;
    step();

    // Zero-wait fetch from 1000:0010.
    load_new_ip = 1; new_cs = 16'h1000; new_ip = 16'h0010;
    step();
    load_new_ip = 0;
    chk("lo req address", 32'(mem_address), 32'h08008);
    chk("lo req access", 32'(mem_access), 32'h1);
    chk("flush pulse", 32'(fifo_reset), 32'h1);
    mem_ack = 1; mem_data = 16'h1111;
    step();
    chk("hi req address", 32'(mem_address), 32'h08009);
    chk("flush one cycle", 32'(fifo_reset), 32'h0);
    mem_data = 16'h2222;
    step();
    chk("push cycle no access", 32'(mem_access), 32'h0);
    mem_ack = 0;
    step();
    chk("first push strobe", 32'(fifo_wr_en), 32'h1);
    chk("first push data", fifo_wr_data, 32'h2222_1111);

    // Next entry stalls behind a full FIFO for five cycles.
    mem_ack = 1; mem_data = 16'h3333;
    step();
    mem_data = 16'h4444;
    step();
    mem_ack = 0; fifo_full = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("full holds wr_en", 32'(fifo_wr_en), 32'h0);
      chk("full no access", 32'(mem_access), 32'h0);
    end
    fifo_full = 0;
    step();
    chk("push after full", 32'(fifo_wr_en), 32'h1);
    chk("push after full data", fifo_wr_data, 32'h4444_3333);

    // Segment wrap at F000:FFFE; the ack coinciding with the load is discarded.
    load_new_ip = 1; new_cs = 16'hF000; new_ip = 16'hFFFE; mem_ack = 1; mem_data = 16'hBAD0;
    step();
    load_new_ip = 0;
    chk("wrap lo address", 32'(mem_address), 32'h7FFFF);
    chk("wrap lo fetch_ip", 32'(fetch_ip), 32'hFFFE);
    mem_data = 16'hAAAA;
    step();
    chk("wrap hi address", 32'(mem_address), 32'h78000);
    chk("wrap fetch_ip 0", 32'(fetch_ip), 32'h0000);
    mem_data = 16'hBBBB;
    step();
    chk("wrap fetch_ip 2", 32'(fetch_ip), 32'h0002);
    mem_ack = 0;

    // Restart in the cycle PUSH would commit.
    load_new_ip = 1; new_cs = 16'h2000; new_ip = 16'h0100;
    step();
    load_new_ip = 0;
    chk("collide no wr_en", 32'(fifo_wr_en), 32'h0);
    chk("collide flush", 32'(fifo_reset), 32'h1);
    chk("collide refetch addr", 32'(mem_address), 32'h10080);
    step();
    chk("collide no wr_en next", 32'(fifo_wr_en), 32'h0);

    // Restart while a request is outstanding; ack withheld three cycles.
    load_new_ip = 1; new_cs = 16'h3000; new_ip = 16'h0203;
    step();
    load_new_ip = 0;
    chk("abort flush", 32'(fifo_reset), 32'h1);
    chk("abort holds address", 32'(mem_address), 32'h10080);
    chk("abort fetch_ip", 32'(fetch_ip), 32'h0202);
    step();
    chk("abort access held", 32'(mem_access), 32'h1);
    step();
    chk("abort access held 2", 32'(mem_access), 32'h1);
    mem_ack = 1; mem_data = 16'hDEAD;
    step();
    chk("post abort address", 32'(mem_address), 32'h18101);
    chk("post abort access", 32'(mem_access), 32'h1);
    mem_data = 16'h5555;
    step();
    mem_data = 16'h6666;
    step();
    mem_ack = 0;
    step();
    chk("post abort push data", fifo_wr_data, 32'h6666_5555);

    // Odd offset is word-aligned.
    load_new_ip = 1; new_cs = 16'h0000; new_ip = 16'h0003; mem_ack = 1;
    step();
    load_new_ip = 0; mem_ack = 0;
    chk("odd ip fetch_ip", 32'(fetch_ip), 32'h0002);
    chk("odd ip address", 32'(mem_address), 32'h00001);

    // Asynchronous reset mid-request.
    #1 reset_n = 0;
    #1 chk("async reset access", 32'(mem_access), 32'h0);
    @(negedge clk);
    reset_n = 1;
    step();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      load_new_ip = ($urandom_range(0, 24) == 0);
      new_cs      = 16'($urandom);
      new_ip      = 16'($urandom);
      fifo_full   = ($urandom_range(0, 2) == 0);
      mem_ack     = mem_access && (c < 1000 ? 1'b1 : ($urandom_range(0, 2) != 0));
      mem_data    = 16'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
